usb_tx_encoder: RTL and testbench

USB_TX_ENCODER -- requirements
Module: usb_tx_encoder

---
 rtl/usb_tx_pkg.sv | 28 ++
 rtl/usb_tx_encoder_if.sv | 9 +
 rtl/usb_tx_bit_timer.sv | 30 +++
 rtl/usb_tx_encoder.sv | 122 ++++++++++++
 tb/tb_usb_tx_encoder.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit encoder.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    EOP_SE0,
    EOP_J
  } tx_state_t;

  // Bus line pair, packed as {d_plus, d_minus}.
  typedef logic [1:0] line_t;

  localparam line_t LINE_J   = 2'b10;
  localparam line_t LINE_K   = 2'b01;
  localparam line_t LINE_SE0 = 2'b00;

  localparam int STUFF_LIMIT_DEFAULT = 6;

  // NRZI: a 0 toggles between J and K, a 1 holds the current line state.
  function automatic line_t nrzi(input logic bit_val, input line_t cur);
    if (bit_val) begin
      return cur;
    end
    return (cur == LINE_J) ? LINE_K : LINE_J;
  endfunction

endpackage

// File: rtl/usb_tx_encoder_if.sv
// Bit-stream handshake between the packet source and the line encoder.
interface usb_tx_encoder_if;
  logic tx_bit;
  logic tx_valid;
  logic tx_ready;

  modport master (output tx_bit, output tx_valid, input tx_ready);
  modport slave  (input tx_bit, input tx_valid, output tx_ready);
endinterface

// File: rtl/usb_tx_bit_timer.sv
// Bit-period timer: counts clocks within one bit slot and flags the boundary.
module usb_tx_bit_timer #(
  parameter int BIT_CLKS = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic en,
  input  logic clr,
  output logic rollover
);

  localparam int CW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CLKS - 1);

  logic [CW-1:0] cnt;

  assign rollover = en && (cnt == LAST);

  // Count while enabled, wrapping at the last clock of the bit slot.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit encoder: bit stuffing, NRZI line coding and EOP.
module usb_tx_encoder
  import usb_tx_pkg::*;
#(
  parameter int BIT_CLKS    = 4,
  parameter int STUFF_LIMIT = STUFF_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              n_rst,
  usb_tx_encoder_if.slave   tx,
  output logic              tx_busy,
  output logic              d_plus,
  output logic              d_minus
);

  localparam int OW = $clog2(STUFF_LIMIT + 1);

  tx_state_t     state;
  line_t         line;
  logic [OW-1:0] ones;
  logic [OW-1:0] ones_base;
  logic [OW-1:0] ones_inc;
  logic          ones_hit;
  logic          stuff_pend;
  logic          se0_second;
  logic          rollover;
  logic          ready_c;

  usb_tx_bit_timer #(.BIT_CLKS(BIT_CLKS)) u_bit_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .en       (state != IDLE),
    .clr      (state == IDLE),
    .rollover (rollover)
  );

  assign {d_plus, d_minus} = line;
  assign tx.tx_ready       = ready_c;

  // Run length of data 1s; a packet always starts counting from zero.
  always_comb begin
    ones_base = (state == IDLE) ? '0 : ones;
    ones_inc  = ones_base + OW'(1);
    ones_hit  = (ones_inc == OW'(STUFF_LIMIT));
  end

  // Accept a bit immediately in IDLE, otherwise only on a free bit boundary.
  always_comb begin
    ready_c = 1'b0;
    if (n_rst) begin
      case (state)
        IDLE:    ready_c = tx.tx_valid;
        ACTIVE:  ready_c = rollover && !stuff_pend;
        default: ready_c = 1'b0;
      endcase
    end
  end

  // Packet FSM with registered line pair, busy flag and stuffing state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      line       <= LINE_J;
      tx_busy    <= 1'b0;
      ones       <= '0;
      stuff_pend <= 1'b0;
      se0_second <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          line       <= LINE_J;
          se0_second <= 1'b0;
          if (tx.tx_valid) begin
            state      <= ACTIVE;
            tx_busy    <= 1'b1;
            line       <= nrzi(tx.tx_bit, LINE_J);
            ones       <= tx.tx_bit ? ones_inc : '0;
            stuff_pend <= tx.tx_bit && ones_hit;
          end
        end
        ACTIVE: begin
          if (rollover) begin
            if (stuff_pend) begin
              line       <= nrzi(1'b0, line);
              ones       <= '0;
              stuff_pend <= 1'b0;
            end else if (tx.tx_valid) begin
              line       <= nrzi(tx.tx_bit, line);
              ones       <= tx.tx_bit ? ones_inc : '0;
              stuff_pend <= tx.tx_bit && ones_hit;
            end else begin
              state <= EOP_SE0;
              line  <= LINE_SE0;
            end
          end
        end
        EOP_SE0: begin
          // SE0 spans two bit periods; the first rollover only arms the second.
          if (rollover) begin
            if (se0_second) begin
              state <= EOP_J;
              line  <= LINE_J;
            end else begin
              se0_second <= 1'b1;
            end
          end
        end
        EOP_J: begin
          if (rollover) begin
            state   <= IDLE;
            tx_busy <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          line  <= LINE_J;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Self-checking bench for usb_tx_encoder: table vectors, reset corners and
// randomized packets against a stuff/NRZI waveform model.
module tb_usb_tx_encoder;

  localparam int B  = 4;
  localparam int SL = 6;
  localparam logic [1:0] LJ = 2'b10;
  localparam logic [1:0] LK = 2'b01;
  localparam logic [1:0] LS = 2'b00;

  logic clk = 1'b0;
  logic n_rst;
  logic tx_busy, d_plus, d_minus;

  always #5 clk = ~clk;

  usb_tx_encoder_if tx_if ();

  usb_tx_encoder #(.BIT_CLKS(B), .STUFF_LIMIT(SL)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .tx      (tx_if),
    .tx_busy (tx_busy),
    .d_plus  (d_plus),
    .d_minus (d_minus)
  );

  int checks = 0;
  int errors = 0;

  bit         pkt[$];
  logic [1:0] exp_w[$];
  logic [1:0] obs[$];
  int         exp_data_len;

  typedef struct {
    int          nbits;
    logic [15:0] bits;
    int          nper;
    logic [15:0] jmask;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected line waveform from the packet bits: insert a 0 after every run of
  // SL ones, NRZI-code from J, stretch each bit to B clocks, append the EOP.
  function automatic void build_model();
    bit s[$];
    int run = 0;
    logic [1:0] cur = LJ;
    exp_w.delete();
    foreach (pkt[i]) begin
      s.push_back(pkt[i]);
      if (pkt[i]) begin
        run++;
        if (run == SL) begin
          s.push_back(1'b0);
          run = 0;
        end
      end else begin
        run = 0;
      end
    end
    foreach (s[i]) begin
      if (!s[i]) cur = (cur == LJ) ? LK : LJ;
      repeat (B) exp_w.push_back(cur);
    end
    exp_data_len = exp_w.size();
    repeat (2 * B) exp_w.push_back(LS);
    repeat (B) exp_w.push_back(LJ);
  endfunction

  // Send pkt and compare every clock of the resulting waveform. With hold set,
  // tx_valid is raised during EOP (ready must stay low); with immediate set,
  // the first bit must be accepted on the very first cycle tried.
  task automatic run_packet(input bit hold, input bit immediate);
    int  i = 0, k = 0, cyc = 0, waited = 0;
    bit  started = 0;
    build_model();
    obs.delete();
    while (1) begin
      @(negedge clk);
      if (started) begin
        obs.push_back({d_plus, d_minus});
        chk("line", {30'd0, d_plus, d_minus}, {30'd0, exp_w[k]});
        chk("busy", {31'd0, tx_busy}, 32'd1);
        k++;
      end
      if (i < pkt.size()) begin
        tx_if.tx_valid = 1'b1;
        tx_if.tx_bit   = pkt[i];
      end else if (hold && k > exp_data_len) begin
        tx_if.tx_valid = 1'b1;
        tx_if.tx_bit   = 1'b0;
      end else begin
        tx_if.tx_valid = 1'b0;
        tx_if.tx_bit   = 1'b0;
      end
      #1;
      if (hold && k > exp_data_len) chk("eop_ready", {31'd0, tx_if.tx_ready}, 32'd0);
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        if (!started) begin
          started = 1;
          if (immediate) chk("b2b_accept_wait", waited, 0);
        end
        i++;
      end else if (!started) begin
        waited++;
      end
      if (started && k == exp_w.size()) break;
      cyc++;
      if (cyc > exp_w.size() + 40) begin
        checks++;
        errors++;
        $display("FAIL timeout actual=%0d cycles required<=%0d", cyc, exp_w.size() + 40);
        break;
      end
    end
  endtask

  function automatic logic [1:0] obs_at(input int idx);
    if (idx < obs.size()) return obs[idx];
    return 2'b11;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog actual=expired required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] want;
    bit prev_hold, next_hold;
    int len;

    vt[0] = '{nbits: 8,  bits: 16'h0080, nper: 8,  jmask: 16'h002A};
    vt[1] = '{nbits: 15, bits: 16'h7F80, nper: 16, jmask: 16'hE02A};
    vt[2] = '{nbits: 6,  bits: 16'h003F, nper: 7,  jmask: 16'h003F};
    vt[3] = '{nbits: 1,  bits: 16'h0000, nper: 1,  jmask: 16'h0000};
    vt[4] = '{nbits: 4,  bits: 16'h0005, nper: 4,  jmask: 16'h0009};
    vt[5] = '{nbits: 12, bits: 16'h0FFF, nper: 14, jmask: 16'h203F};

    // Reset: ready must stay low even with valid asserted.
    n_rst = 1'b0;
    tx_if.tx_valid = 1'b1;
    tx_if.tx_bit   = 1'b0;
    #12;
    chk("rst_ready", {31'd0, tx_if.tx_ready}, 32'd0);
    chk("rst_lines", {30'd0, d_plus, d_minus}, {30'd0, LJ});
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    tx_if.tx_valid = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle_lines", {30'd0, d_plus, d_minus}, {30'd0, LJ});
      chk("idle_busy", {31'd0, tx_busy}, 32'd0);
      chk("idle_ready", {31'd0, tx_if.tx_ready}, 32'd0);
    end

    // Table vectors: per-bit-period line state, then EOP start.
    for (int v = 0; v < 6; v++) begin
      pkt.delete();
      for (int b = 0; b < vt[v].nbits; b++) pkt.push_back(vt[v].bits[b]);
      run_packet(0, 0);
      for (int p = 0; p < vt[v].nper; p++) begin
        want = vt[v].jmask[p] ? LJ : LK;
        chk($sformatf("vec%0d_per%0d", v, p), {30'd0, obs_at(p * B + 1)}, {30'd0, want});
      end
      chk($sformatf("vec%0d_se0", v), {30'd0, obs_at(vt[v].nper * B)}, {30'd0, LS});
      chk($sformatf("vec%0d_len", v), obs.size(), vt[v].nper * B + 3 * B);
      repeat (2) @(negedge clk);
    end

    // Reset mid-packet: lines jump to J without an edge, busy drops.
    @(negedge clk);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_bit   = 1'b0;
    #1;
    chk("mid_start_ready", {31'd0, tx_if.tx_ready}, 32'd1);
    repeat (9) @(posedge clk);
    #2;
    chk("mid_pre_lines", {30'd0, d_plus, d_minus}, {30'd0, LK});
    chk("mid_pre_busy", {31'd0, tx_busy}, 32'd1);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_lines", {30'd0, d_plus, d_minus}, {30'd0, LJ});
    chk("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, tx_if.tx_ready}, 32'd0);
    tx_if.tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    pkt = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    run_packet(0, 0);

    // Back-to-back: valid held through EOP, accepted in the first IDLE cycle.
    pkt = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    run_packet(1, 0);
    pkt = '{1'b0, 1'b1, 1'b0};
    run_packet(0, 1);

    // Randomized packets, biased toward 1s to exercise stuffing.
    prev_hold = 0;
    for (int r = 0; r < 25; r++) begin
      pkt.delete();
      len = $urandom_range(1, 24);
      for (int b = 0; b < len; b++) pkt.push_back(($urandom % 4) != 0);
      next_hold = (r < 24) && (($urandom % 3) == 0);
      run_packet(next_hold, prev_hold);
      prev_hold = next_hold;
      if (!next_hold) repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    @(negedge clk);
    chk("end_lines", {30'd0, d_plus, d_minus}, {30'd0, LJ});
    chk("end_busy", {31'd0, tx_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
